picoctrl_sequencer: RTL and testbench

Execution engine for the PicoCtrl instruction ROM. It holds the program counter and drives the 5-bit ROM address. Each cycle it decodes the returned 16-bit instruction, tests its condition against the external condition inputs, and performs a register write, jump, or halt. It sits between the 32-entry instruction ROM and the four 8-bit output registers that drive the board (LEDs, enables).

---
 rtl/picoctrl_sequencer_if.sv | 21 ++
 rtl/picoctrl_sequencer.sv | 78 +++++++
 tb/tb_picoctrl_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/picoctrl_sequencer_if.sv
// picoctrl_sequencer_if: sequencer bus (run, ROM fetch, condition inputs, output registers, strobes, halt flag); master = sequencer, slave = environment
interface picoctrl_sequencer_if;
  logic        run;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  cond_in;
  logic [7:0]  reg0_out;
  logic [7:0]  reg1_out;
  logic [7:0]  reg2_out;
  logic [7:0]  reg3_out;
  logic [3:0]  wr_strobe;
  logic        halted;
  modport master (
    input  run, rom_data, cond_in,
    output rom_addr, reg0_out, reg1_out, reg2_out, reg3_out, wr_strobe, halted
  );
  modport slave (
    output run, rom_data, cond_in,
    input  rom_addr, reg0_out, reg1_out, reg2_out, reg3_out, wr_strobe, halted
  );
endinterface

// File: rtl/picoctrl_sequencer.sv
// picoctrl_sequencer: PicoCtrl ROM execution engine (PC, condition test, reg write/jump/halt); ports clk, rst_n (sync active-low), bus (picoctrl_sequencer_if.master); define PICOCTRL_SYNC_EN for a 2-flop cond_in synchronizer
module picoctrl_sequencer #(
  parameter logic [4:0] RESET_PC  = 5'h00,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input logic                        clk,
  input logic                        rst_n,
  picoctrl_sequencer_if.master       bus
);
  typedef enum logic {RUN, HALT} state_t;
  state_t          state_q, state_d;
  logic [4:0]      pc_q, pc_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [3:0]      strobe_q, strobe_d;
  logic [3:0]      cond_v;
  logic [3:0]      cond;
  logic [1:0]      act, sel;
  logic [7:0]      imm;
  logic            cond_true;
`ifdef PICOCTRL_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.cond_in;
      sync2_q <= sync1_q;
    end
  end
  assign cond_v = sync2_q;
`else
  assign cond_v = bus.cond_in;
`endif
  assign cond      = bus.rom_data[15:12];
  assign act       = bus.rom_data[11:10];
  assign sel       = bus.rom_data[9:8];
  assign imm       = bus.rom_data[7:0];
  assign cond_true = cond[3] ? (cond_v[cond[2:1]] == cond[0]) : !cond[0];
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    regs_d   = regs_q;
    strobe_d = '0;
    if (state_q == RUN && bus.run) begin
      pc_d = pc_q + 5'd1;
      if (cond_true && act == 2'b01) begin
        regs_d[sel] = imm;
        strobe_d    = 4'b0001 << sel;
      end else if (cond_true && act == 2'b10) begin
        pc_d = imm[4:0];
      end else if (cond_true && act == 2'b11) begin
        pc_d    = pc_q;
        state_d = HALT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      regs_q   <= {4{REG_RESET}};
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
    end
  end
  assign bus.rom_addr  = pc_q;
  assign bus.reg0_out  = regs_q[0];
  assign bus.reg1_out  = regs_q[1];
  assign bus.reg2_out  = regs_q[2];
  assign bus.reg3_out  = regs_q[3];
  assign bus.wr_strobe = strobe_q;
  assign bus.halted    = state_q == HALT;
endmodule

// File: tb/tb_picoctrl_sequencer.sv
// tb_picoctrl_sequencer: randomized and directed checks of picoctrl_sequencer against a behavioural model
module tb_picoctrl_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
`ifdef PICOCTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic [15:0] rom [32];
  logic [4:0]  m_pc;
  logic [7:0]  m_reg [4];
  logic [3:0]  m_stb;
  logic        m_halt;
  logic [3:0]  h1, h2;
  picoctrl_sequencer_if bus ();
  picoctrl_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.rom_data = rom[bus.rom_addr];
  always #5 clk = ~clk;
  function automatic logic [15:0] mk(logic [3:0] c, logic [1:0] a, logic [1:0] s, logic [7:0] i);
    return {c, a, s, i};
  endfunction
  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
  endtask
  task automatic tick();
    logic [15:0] ins;
    logic [3:0] c;
    logic ok;
    ins = rom[m_pc];
`ifdef PICOCTRL_SYNC_EN
    c = h2;
`else
    c = bus.cond_in;
`endif
    ok = ins[15] ? (c[ins[14:13]] == ins[12]) : !ins[12];
    m_stb = 4'h0;
    if (!rst_n) begin
      m_pc = 5'h00;
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_halt = 1'b0;
      h1 = 4'h0;
      h2 = 4'h0;
    end else begin
      if (!m_halt && bus.run) begin
        if (!ok || ins[11:10] == 2'd0) m_pc = m_pc + 5'd1;
        else if (ins[11:10] == 2'd1) begin
          m_reg[ins[9:8]] = ins[7:0];
          m_stb[ins[9:8]] = 1'b1;
          m_pc = m_pc + 5'd1;
        end else if (ins[11:10] == 2'd2) m_pc = ins[4:0];
        else m_halt = 1'b1;
      end
      h2 = h1;
      h1 = bus.cond_in;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    clear_rom();
    bus.run = 1'b1;
    bus.cond_in = 4'h0;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (bus.rom_addr !== 5'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", bus.rom_addr); end
    total++; if ({bus.reg3_out, bus.reg2_out, bus.reg1_out, bus.reg0_out} !== 32'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {bus.reg3_out, bus.reg2_out, bus.reg1_out, bus.reg0_out}); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    total++; if (bus.wr_strobe !== 4'h0) begin bad++; $display("FAIL reset_strobe got=%b exp=0000", bus.wr_strobe); end
    rst_n = 1'b1;
  endtask
  task automatic test_write();
    clear_rom();
    rom[0] = mk(4'h0, 2'd1, 2'd1, 8'h01);
    do_reset();
    tick();
    total++; if (bus.reg1_out !== 8'h01) begin bad++; $display("FAIL write_reg1 got=%h exp=01", bus.reg1_out); end
    total++; if (bus.wr_strobe !== 4'b0010) begin bad++; $display("FAIL write_strobe got=%b exp=0010", bus.wr_strobe); end
    total++; if (bus.rom_addr !== 5'h01) begin bad++; $display("FAIL write_pc got=%h exp=01", bus.rom_addr); end
    tick();
    total++; if (bus.wr_strobe !== 4'b0000) begin bad++; $display("FAIL write_strobe_drop got=%b exp=0000", bus.wr_strobe); end
    total++; if (bus.reg1_out !== 8'h01) begin bad++; $display("FAIL write_hold got=%h exp=01", bus.reg1_out); end
  endtask
  task automatic test_wait_loop();
    int n;
    clear_rom();
    rom[3] = mk(4'hB, 2'd2, 2'd0, 8'h03);
    bus.cond_in = 4'b0010;
    do_reset();
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.rom_addr !== 5'h03 || m_pc !== 5'h03) begin bad++; $display("FAIL wait_hold cycle=%0d got=%h exp=03", i, bus.rom_addr); end
    end
    bus.cond_in = 4'b0000;
    n = 0;
    do begin
      tick();
      n++;
      total++; if (bus.rom_addr !== m_pc) begin bad++; $display("FAIL wait_model got=%h exp=%h", bus.rom_addr, m_pc); end
    end while (bus.rom_addr == 5'h03 && n < 10);
    total++; if (n !== 1 + LAT) begin bad++; $display("FAIL wait_exit_latency got=%0d exp=%0d", n, 1 + LAT); end
    total++; if (bus.rom_addr !== 5'h04) begin bad++; $display("FAIL wait_fallthrough got=%h exp=04", bus.rom_addr); end
  endtask
  task automatic test_wrap_jump();
    logic [4:0] exp_seq [3];
    exp_seq = '{5'h1e, 5'h1f, 5'h00};
    clear_rom();
    rom[0] = mk(4'h0, 2'd2, 2'd0, 8'hFE);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.rom_addr !== exp_seq[i]) begin bad++; $display("FAIL wrap step=%0d got=%h exp=%h", i, bus.rom_addr, exp_seq[i]); end
    end
    rom[0] = mk(4'h0, 2'd2, 2'd0, 8'hE3);
    tick();
    total++; if (bus.rom_addr !== 5'h03) begin bad++; $display("FAIL jump_imm got=%h exp=03", bus.rom_addr); end
  endtask
  task automatic test_halt();
    clear_rom();
    rom[1] = mk(4'h1, 2'd3, 2'd0, 8'h00);
    rom[3] = mk(4'h0, 2'd3, 2'd0, 8'h00);
    rom[4] = mk(4'h0, 2'd1, 2'd2, 8'h77);
    do_reset();
    repeat (3) tick();
    total++; if (bus.rom_addr !== 5'h03 || bus.halted !== 1'b0) begin bad++; $display("FAIL never_halt pc=%h halted=%b exp pc=03 halted=0", bus.rom_addr, bus.halted); end
    tick();
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_enter got=%b exp=1", bus.halted); end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (bus.rom_addr !== 5'h03 || bus.halted !== 1'b1 || bus.reg2_out !== 8'h00) begin bad++; $display("FAIL halt_hold cycle=%0d pc=%h halted=%b reg2=%h exp pc=03 halted=1 reg2=00", i, bus.rom_addr, bus.halted, bus.reg2_out); end
    end
    rom[0] = mk(4'h0, 2'd1, 2'd2, 8'hAA);
    do_reset();
    total++; if (bus.rom_addr !== 5'h00 || bus.halted !== 1'b0) begin bad++; $display("FAIL halt_reset pc=%h halted=%b exp pc=00 halted=0", bus.rom_addr, bus.halted); end
    total++; if (bus.reg2_out !== 8'h00 || bus.wr_strobe !== 4'h0) begin bad++; $display("FAIL reset_wins reg2=%h strobe=%b exp 00 0000", bus.reg2_out, bus.wr_strobe); end
  endtask
  task automatic test_run_gate();
    clear_rom();
    rom[0] = mk(4'h0, 2'd1, 2'd0, 8'h55);
    do_reset();
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.reg0_out !== 8'h00 || bus.wr_strobe !== 4'h0 || bus.rom_addr !== 5'h00) begin bad++; $display("FAIL run_gate cycle=%0d reg0=%h strobe=%b pc=%h exp 00 0000 00", i, bus.reg0_out, bus.wr_strobe, bus.rom_addr); end
    end
    bus.run = 1'b1;
    tick();
    total++; if (bus.reg0_out !== 8'h55 || bus.wr_strobe !== 4'b0001) begin bad++; $display("FAIL run_resume reg0=%h strobe=%b exp 55 0001", bus.reg0_out, bus.wr_strobe); end
  endtask
  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 32; i++) begin
      w = 16'($urandom);
      if (w[11:10] == 2'd3 && $urandom_range(3, 0) != 0) w[11:10] = 2'd0;
      rom[i] = w;
    end
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.cond_in = 4'($urandom);
      bus.run = $urandom_range(7, 0) != 0;
      rst_n = $urandom_range(29, 0) != 0;
      tick();
      total++;
      if (bus.rom_addr !== m_pc || bus.halted !== m_halt || bus.wr_strobe !== m_stb ||
          {bus.reg3_out, bus.reg2_out, bus.reg1_out, bus.reg0_out} !== {m_reg[3], m_reg[2], m_reg[1], m_reg[0]}) begin
        bad++;
        $display("FAIL random cycle=%0d got pc=%h h=%b s=%b r=%h exp pc=%h h=%b s=%b r=%h", i,
                 bus.rom_addr, bus.halted, bus.wr_strobe, {bus.reg3_out, bus.reg2_out, bus.reg1_out, bus.reg0_out},
                 m_pc, m_halt, m_stb, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
      end
    end
    rst_n = 1'b1;
    bus.run = 1'b1;
  endtask
  initial begin
    bus.run = 1'b1;
    bus.cond_in = 4'h0;
    m_pc = 5'h00;
    m_halt = 1'b0;
    m_stb = 4'h0;
    h1 = 4'h0;
    h2 = 4'h0;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    test_reset();
    test_write();
    test_wait_loop();
    test_wrap_jump();
    test_halt();
    test_run_gate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
